// File: rtl/wb_uart_arbiter_pkg.sv
// Shared definitions for the Wishbone UART-bridge arbiter.
// State encodings and a width helper that stays >= 1 bit.
package wb_uart_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    function automatic int clog2_safe(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_uart_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i,
// wrapping around; last_i itself is considered last.
module wb_uart_arbiter_rr_pick
    import wb_uart_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int GW = clog2_safe(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_i,
    output logic          valid_o,
    output logic [GW-1:0] idx_o
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = GW'((int'(last_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/wb_uart_arbiter.sv
// Round-robin Wishbone arbiter sharing one wb2uart bridge slave,
// one transaction at a time with a grant-to-ack timeout.
module wb_uart_arbiter
    import wb_uart_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS    = 2,
    parameter  int ADDR_WIDTH     = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int SEL_WIDTH      = 1,
    parameter  int TIMEOUT_CYCLES = 1000000,
    localparam int GW             = clog2_safe(NUM_MASTERS),
    localparam int CW             = clog2_safe(TIMEOUT_CYCLES)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_datwr,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
    output logic [DATA_WIDTH-1:0]             m_datrd,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [ADDR_WIDTH-1:0]             s_adr,
    output logic [DATA_WIDTH-1:0]             s_datwr,
    output logic [SEL_WIDTH-1:0]              s_sel,
    input  logic [DATA_WIDTH-1:0]             s_datrd,
    input  logic                              s_ack,
    output logic [GW-1:0]                     grant
);

    arb_state_e             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] req;
    logic                   pick_vld;
    logic [GW-1:0]          pick_idx;
    logic                   own_cyc;

    assign req   = m_cyc & m_stb;
    assign grant = grant_q;

    wb_uart_arbiter_rr_pick #(
        .N(NUM_MASTERS)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        own_cyc = 1'b0;
        m_ack   = '0;
        m_err   = '0;
        m_datrd = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Owner dropping cyc aborts silently; the slave sees it at once.
                if (!m_cyc[grant_q]) begin
                    state_d = ARB_RELEASE;
                end else begin
                    own_cyc = 1'b1;
                    if (s_ack) begin
                        m_ack[grant_q] = 1'b1;
                        m_datrd        = s_datrd;
                        last_d         = grant_q;
                        state_d        = ARB_RELEASE;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        m_err[grant_q] = 1'b1;
                        state_d        = ARB_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ARB_RELEASE: begin
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_cyc   = own_cyc;
        s_stb   = own_cyc;
        s_we    = 1'b0;
        s_adr   = '0;
        s_datwr = '0;
        s_sel   = '0;
        if (own_cyc) begin
            s_we    = m_we[grant_q];
            s_adr   = m_adr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_datwr = m_datwr[grant_q*DATA_WIDTH +: DATA_WIDTH];
            s_sel   = m_sel[grant_q*SEL_WIDTH +: SEL_WIDTH];
        end
    end

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Directed bench for wb_uart_arbiter: a long-timeout instance for the
// protocol steps and a TIMEOUT_CYCLES=16 instance for the timeout step.
module tb_wb_uart_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we, m_sel;
    logic [7:0]  m_adr;
    logic [15:0] m_datwr;
    logic [7:0]  s_datrd;
    logic        s_ack;

    logic [7:0]  m_datrd;
    logic [1:0]  m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_adr;
    logic [7:0]  s_datwr;
    logic [0:0]  s_sel;
    logic [0:0]  grant;

    logic [7:0]  t_m_datrd;
    logic [1:0]  t_m_ack, t_m_err;
    logic        t_s_cyc, t_s_stb, t_s_we;
    logic [3:0]  t_s_adr;
    logic [7:0]  t_s_datwr;
    logic [0:0]  t_s_sel;
    logic [0:0]  t_grant;

    int n_assert = 0;
    int n_fail   = 0;
    logic early;

    wb_uart_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(4), .DATA_WIDTH(8),
        .SEL_WIDTH(1), .TIMEOUT_CYCLES(64)
    ) dut (
        .clock(clk), .reset(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_datwr(m_datwr), .m_sel(m_sel), .m_datrd(m_datrd),
        .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_datwr(s_datwr), .s_sel(s_sel), .s_datrd(s_datrd),
        .s_ack(s_ack), .grant(grant)
    );

    wb_uart_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(4), .DATA_WIDTH(8),
        .SEL_WIDTH(1), .TIMEOUT_CYCLES(16)
    ) dut_to (
        .clock(clk), .reset(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_datwr(m_datwr), .m_sel(m_sel), .m_datrd(t_m_datrd),
        .m_ack(t_m_ack), .m_err(t_m_err),
        .s_cyc(t_s_cyc), .s_stb(t_s_stb), .s_we(t_s_we), .s_adr(t_s_adr),
        .s_datwr(t_s_datwr), .s_sel(t_s_sel), .s_datrd(s_datrd),
        .s_ack(1'b0), .grant(t_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_adr = '0; m_datwr = '0; s_datrd = '0; s_ack = 1'b0;
        #1;
        chk("rst_main", 32'({s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel,
                             m_datrd, m_ack, m_err, grant}), 0);
        chk("rst_to", 32'({t_s_cyc, t_s_stb, t_s_we, t_s_adr, t_s_datwr,
                           t_s_sel, t_m_datrd, t_m_ack, t_m_err, t_grant}), 0);
        @(negedge clk) rst_n = 1'b1;

        // Single master 0 read, ack after 20 BUSY cycles
        @(negedge clk);
        m_cyc = 2'b01; m_stb = 2'b01; m_adr = 8'h03;
        #1 chk("t1_stb_pre", s_stb, 0);
        @(negedge clk);
        chk("t1_stb", s_stb, 1);
        chk("t1_grant", grant, 0);
        chk("t1_adr", s_adr, 4'h3);
        chk("t1_we", s_we, 0);
        repeat (18) @(negedge clk);
        chk("t1_noack", m_ack, 0);
        @(negedge clk);
        s_ack = 1'b1; s_datrd = 8'hA5;
        #1 chk("t1_ack", m_ack, 2'b01);
        chk("t1_dat", m_datrd, 8'hA5);
        chk("t1_err", m_err, 0);
        @(negedge clk);
        s_ack = 1'b0; s_datrd = '0; m_cyc = '0; m_stb = '0;
        #1 chk("t1_rel", s_stb, 0);
        chk("t1_rel_ack", m_ack, 0);

        // Simultaneous requests from reset pointer alternate 0,1,0,1
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_cyc = 2'b11; m_stb = 2'b11; m_adr = 8'h21;
            @(negedge clk);
            s_ack = 1'b1; s_datrd = 8'(8'h10 + i);
            #1 chk("t2_grant", grant, 32'(i % 2));
            chk("t2_ack", m_ack, (i % 2 == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            s_ack = 1'b0;
            #1 chk("t2_rel", s_cyc, 0);
        end
        m_cyc = '0; m_stb = '0;

        // Master 1 write while master 0 waits
        @(negedge clk);
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
        m_adr = 8'h23; m_datwr = 16'h5C00; m_sel = 2'b10;
        @(negedge clk);
        m_cyc = 2'b11; m_stb = 2'b11;
        #1 chk("t3_grant", grant, 1);
        chk("t3_we", s_we, 1);
        chk("t3_adr", s_adr, 4'h2);
        chk("t3_dat", s_datwr, 8'h5C);
        chk("t3_sel", s_sel, 1);
        chk("t3_m0_wait", m_ack, 0);
        @(negedge clk);
        s_ack = 1'b1;
        #1 chk("t3_ack", m_ack, 2'b10);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; m_we = '0;
        #1 chk("t3_rel", s_stb, 0);
        chk("t3_rel_ack", m_ack, 0);
        @(negedge clk);
        chk("t3_idle", s_stb, 0);
        @(negedge clk);
        chk("t3_m0_grant", grant, 0);
        chk("t3_m0_adr", s_adr, 4'h3);
        chk("t3_m0_we", s_we, 0);
        s_ack = 1'b1; s_datrd = 8'h3C;
        #1 chk("t3_m0_ack", m_ack, 2'b01);
        chk("t3_m0_dat", m_datrd, 8'h3C);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;

        // Granted master 1 aborts; master 0 follows after RELEASE
        @(negedge clk);
        m_cyc = 2'b11; m_stb = 2'b11;
        @(negedge clk);
        chk("t4_grant", grant, 1);
        chk("t4_stb", s_stb, 1);
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b1;
        #1 chk("t4_cyc_drop", s_cyc, 0);
        chk("t4_stb_drop", s_stb, 0);
        chk("t4_no_ack", m_ack, 0);
        chk("t4_no_err", m_err, 0);
        @(negedge clk);
        s_ack = 1'b0;
        chk("t4_rel", s_cyc, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_m0_stb", s_stb, 1);
        s_ack = 1'b1;
        #1 chk("t4_m0_grant", grant, 0);
        chk("t4_m0_ack", m_ack, 2'b01);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;

        // Reset during BUSY, then a clean transaction
        @(negedge clk);
        m_cyc = 2'b10; m_stb = 2'b10;
        @(negedge clk);
        chk("t5_grant", grant, 1);
        chk("t5_cyc", s_cyc, 1);
        rst_n = 1'b0; s_ack = 1'b1; s_datrd = 8'h77;
        #1 chk("t5_rst_cyc", s_cyc, 0);
        chk("t5_rst_stb", s_stb, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_ack", m_ack, 0);
        chk("t5_rst_dat", m_datrd, 0);
        @(negedge clk);
        rst_n = 1'b1; s_ack = 1'b0;
        @(negedge clk);
        chk("t5_again_stb", s_stb, 1);
        s_ack = 1'b1; s_datrd = 8'h99;
        #1 chk("t5_again_grant", grant, 1);
        chk("t5_again_ack", m_ack, 2'b10);
        chk("t5_again_dat", m_datrd, 8'h99);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;

        // Silent slave on the 16-cycle timeout instance
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; m_cyc = 2'b01; m_stb = 2'b01;
        early = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (t_m_err != 2'b00) early = 1'b1;
        end
        chk("to_early", early, 0);
        chk("to_stb15", t_s_stb, 1);
        @(negedge clk);
        chk("to_err", t_m_err, 2'b01);
        chk("to_err_stb", t_s_stb, 1);
        chk("to_err_ack", t_m_ack, 0);
        @(negedge clk);
        chk("to_rel_err", t_m_err, 0);
        chk("to_rel_stb", t_s_stb, 0);
        @(negedge clk);
        chk("to_idle_stb", t_s_stb, 0);
        @(negedge clk);
        chk("to_regrant_stb", t_s_stb, 1);
        chk("to_regrant", t_grant, 0);
        m_cyc = '0; m_stb = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
